// File: rtl/atmega_tim_pkg.sv
// Shared constants for the ATmega timer subsystem: GTCCR bit positions,
// prescaler tap positions and IO bus defaults.
package atmega_tim_pkg;
    localparam int BUS_ADDR_DATA_LEN_DEF = 8;
    localparam logic [7:0] GTCCR_ADDR_DEF = 8'h43;

    localparam int TSM     = 7;
    localparam int PSRASY  = 1;
    localparam int PSRSYNC = 0;

    localparam int PRESC_W     = 10;
    localparam int TAP_CLK8    = 2;
    localparam int TAP_CLK64   = 5;
    localparam int TAP_CLK256  = 7;
    localparam int TAP_CLK1024 = 9;
endpackage

// File: rtl/atmega_tim_edge_sync.sv
// Two-flop synchroniser for an external timer count pin, followed by a
// previous-value flop that yields one-clk rise/fall pulses.
module atmega_tim_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall
);
    logic s1, s2, p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            p  <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            p  <= s2;
        end
    end

    assign rise = s2 & ~p;
    assign fall = ~s2 & p;
endmodule

// File: rtl/atmega_tim_prescaler.sv
// Shared timer prescaler: free-running 10-bit counter with clk8..clk1024 taps,
// the GTCCR register (TSM/PSRASY/PSRSYNC) and T0/T1 pin edge detection.
module atmega_tim_prescaler
    import atmega_tim_pkg::*;
#(
    parameter int BUS_ADDR_DATA_LEN = BUS_ADDR_DATA_LEN_DEF,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_ADDR = BUS_ADDR_DATA_LEN'(GTCCR_ADDR_DEF)
) (
    input  logic                         rst,
    input  logic                         clk,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [7:0]                   bus_in,
    output logic [7:0]                   bus_out,
    output logic                         clk8,
    output logic                         clk64,
    output logic                         clk256,
    output logic                         clk1024,
    output logic                         psrasy,
    input  logic                         t0,
    input  logic                         t1,
    output logic                         t0_rise,
    output logic                         t0_fall,
    output logic                         t1_rise,
    output logic                         t1_fall
);
    logic [PRESC_W-1:0] cnt;
    logic               tsm, psr_sync, psr_asy;
    logic               gtccr_sel, gtccr_wr;
    logic               unused_bus_bits;

    assign gtccr_sel       = (addr == GTCCR_ADDR);
    assign gtccr_wr        = wr & gtccr_sel;
    assign unused_bus_bits = ^bus_in[6:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            tsm      <= 1'b0;
            psr_sync <= 1'b0;
            psr_asy  <= 1'b0;
        end else begin
            // PSR bits only stick while TSM is written 1; otherwise they self-clear.
            if (gtccr_wr) begin
                tsm      <= bus_in[TSM];
                psr_sync <= bus_in[PSRSYNC] & bus_in[TSM];
                psr_asy  <= bus_in[PSRASY] & bus_in[TSM];
            end else if (!tsm) begin
                psr_sync <= 1'b0;
                psr_asy  <= 1'b0;
            end

            if (psr_sync || (gtccr_wr && bus_in[PSRSYNC]))
                cnt <= '0;
            else
                cnt <= cnt + PRESC_W'(1);
        end
    end

    always_comb begin
        bus_out = 8'h00;
        if (rd && gtccr_sel) begin
            bus_out[TSM]     = tsm;
            bus_out[PSRASY]  = psr_asy;
            bus_out[PSRSYNC] = psr_sync;
        end
    end

    assign clk8    = cnt[TAP_CLK8];
    assign clk64   = cnt[TAP_CLK64];
    assign clk256  = cnt[TAP_CLK256];
    assign clk1024 = cnt[TAP_CLK1024];

    // The write-cycle term guarantees the async prescaler sees at least one clk of request.
    assign psrasy = psr_asy | (gtccr_wr & bus_in[PSRASY]);

    atmega_tim_edge_sync u_t0_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (t0),
        .rise (t0_rise),
        .fall (t0_fall)
    );

    atmega_tim_edge_sync u_t1_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (t1),
        .rise (t1_rise),
        .fall (t1_fall)
    );
endmodule
